// File: rtl/key_scan_debounce.sv
// Matrix keypad front-end: one-hot 4-column scan of 5 row-sense lines (20 keys),
// with input synchronisation, full-frame debouncing and press/release strobes.
module key_scan_debounce #(
  parameter int SCAN_DIV        = 1000,
  parameter int DEBOUNCE_FRAMES = 50
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic [4:0] i_key_in,
  output logic [3:0] o_key_out,
  output logic [4:0] o_key_code,
  output logic       o_key_valid,
  output logic       o_key_release,
  output logic       o_key_held
);

  localparam int DIV_W = $clog2(SCAN_DIV);
  localparam int CNT_W = $clog2(DEBOUNCE_FRAMES);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_FRAMES - 1);

  logic [4:0]       key_meta;
  logic [4:0]       key_sync;
  logic [DIV_W-1:0] div;
  logic [1:0]       col;
  logic [1:0]       acc_hits;
  logic [4:0]       acc_code;
  logic [4:0]       candidate;
  logic [CNT_W-1:0] stable_cnt;
  logic [4:0]       key_code;
  logic             key_valid;
  logic             key_release;

  logic [1:0] col_hits;
  logic [2:0] col_row;
  logic [4:0] col_code;
  logic [1:0] merged_hits;
  logic [4:0] merged_code;
  logic [4:0] frame_result;
  logic       sample;
  logic       frame_done;
  logic       accept;

  // Hit count saturates at 2: anything beyond one hit per frame is a ghost/multi-press.
  always_comb begin
    col_hits = 2'd0;
    col_row  = 3'd0;
    for (int r = 0; r < 5; r++) begin
      if (key_sync[r]) begin
        col_row = 3'(r);
        if (col_hits != 2'd2) col_hits = col_hits + 2'd1;
      end
    end
    col_code = ({3'b000, col} * 5'd5) + {2'b00, col_row} + 5'd1;

    if (col_hits == 2'd0) begin
      merged_hits = acc_hits;
      merged_code = acc_code;
    end else if (acc_hits == 2'd0 && col_hits == 2'd1) begin
      merged_hits = 2'd1;
      merged_code = col_code;
    end else begin
      merged_hits = 2'd2;
      merged_code = acc_code;
    end

    frame_result = (merged_hits == 2'd1) ? merged_code : 5'd0;
  end

  assign sample     = (div == DIV_LAST);
  assign frame_done = sample && (col == 2'd3);
  assign accept     = (stable_cnt == CNT_LAST) && (candidate != key_code);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      key_meta    <= '0;
      key_sync    <= '0;
      div         <= '0;
      col         <= '0;
      acc_hits    <= '0;
      acc_code    <= '0;
      candidate   <= '0;
      stable_cnt  <= '0;
      key_code    <= '0;
      key_valid   <= 1'b0;
      key_release <= 1'b0;
    end else begin
      key_meta <= i_key_in;
      key_sync <= key_meta;

      if (sample) begin
        div <= '0;
        col <= col + 2'd1;
      end else begin
        div <= div + DIV_W'(1);
      end

      if (sample) begin
        if (col == 2'd3) begin
          acc_hits <= '0;
          acc_code <= '0;
        end else begin
          acc_hits <= merged_hits;
          acc_code <= merged_code;
        end
      end

      if (frame_done) begin
        if (frame_result == candidate) begin
          if (stable_cnt != CNT_LAST) stable_cnt <= stable_cnt + CNT_W'(1);
        end else begin
          candidate  <= frame_result;
          stable_cnt <= '0;
        end
      end

      // A direct key-to-key change pulses both strobes together.
      key_valid   <= 1'b0;
      key_release <= 1'b0;
      if (accept) begin
        key_code    <= candidate;
        key_valid   <= (candidate != 5'd0);
        key_release <= (key_code != 5'd0);
      end
    end
  end

  assign o_key_out     = 4'b0001 << col;
  assign o_key_code    = key_code;
  assign o_key_valid   = key_valid;
  assign o_key_release = key_release;
  assign o_key_held    = (key_code != 5'd0);

endmodule

// File: tb/tb_key_scan_debounce.sv
// Directed bench for key_scan_debounce with a behavioural keypad matrix
// (SCAN_DIV=4, DEBOUNCE_FRAMES=3, 16-cycle frames).
module tb_key_scan_debounce;

  logic       clk;
  logic       rst;
  logic [4:0] key_in;
  logic [3:0] key_out;
  logic [4:0] key_code;
  logic       key_valid;
  logic       key_release;
  logic       key_held;

  logic [19:0] keys_down;
  int checks;
  int errors;
  int valid_cnt;
  int release_cnt;

  key_scan_debounce #(.SCAN_DIV(4), .DEBOUNCE_FRAMES(3)) dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_key_in     (key_in),
    .o_key_out    (key_out),
    .o_key_code   (key_code),
    .o_key_valid  (key_valid),
    .o_key_release(key_release),
    .o_key_held   (key_held)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Keypad model: key (col,row) shorts column drive col onto row sense row.
  always_comb begin
    key_in = 5'd0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 5; r++)
        if (keys_down[c*5 + r] && key_out[c]) key_in[r] = 1'b1;
  end

  always @(negedge clk) begin
    if (key_valid) valid_cnt++;
    if (key_release) release_cnt++;
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  task automatic applyStimulus(input logic [19:0] keys);
    keys_down = keys;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Returns just after the edge where column 0 begins a new frame.
  task automatic alignFrame(input string tag);
    logic [3:0] prev;
    logic       found;
    found = 1'b0;
    prev  = key_out;
    for (int i = 0; i < 64 && !found; i++) begin
      step();
      if (key_out == 4'b0001 && prev == 4'b1000) found = 1'b1;
      prev = key_out;
    end
    if (!found) checkOutput(tag, 32'(found), 32'd1);
  endtask

  task automatic waitStrobe(input int limit, output int n, output logic seen);
    n    = 0;
    seen = 1'b0;
    while (n < limit && !seen) begin
      step();
      n++;
      if (key_valid || key_release) seen = 1'b1;
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog got=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [3:0] exp_cols;
    logic       seen;
    int         n;
    int         v0;
    int         r0;

    checks      = 0;
    errors      = 0;
    valid_cnt   = 0;
    release_cnt = 0;
    rst         = 1'b1;
    applyStimulus(20'd0);

    // 1: reset state and idle scanning
    step();
    step();
    checkOutput("rst_key_out", 32'(key_out), 32'd1);
    checkOutput("rst_code", 32'(key_code), 32'd0);
    checkOutput("rst_valid", 32'(key_valid), 32'd0);
    checkOutput("rst_release", 32'(key_release), 32'd0);
    checkOutput("rst_held", 32'(key_held), 32'd0);
    rst = 1'b0;
    v0 = valid_cnt;
    r0 = release_cnt;
    for (int i = 0; i < 200; i++) begin
      exp_cols = 4'b0001 << ((i / 4) % 4);
      checkOutput("t1_col", 32'(key_out), 32'(exp_cols));
      step();
    end
    checkOutput("t1_code", 32'(key_code), 32'd0);
    checkOutput("t1_valid_cnt", 32'(valid_cnt - v0), 32'd0);
    checkOutput("t1_release_cnt", 32'(release_cnt - r0), 32'd0);

    // 2: single key col1,row2 -> code 8
    alignFrame("t2_align");
    v0 = valid_cnt;
    r0 = release_cnt;
    applyStimulus(20'd1 << 7);
    waitStrobe(100, n, seen);
    checkOutput("t2_seen", 32'(seen), 32'd1);
    checkOutput("t2_valid", 32'(key_valid), 32'd1);
    checkOutput("t2_release", 32'(key_release), 32'd0);
    checkOutput("t2_code", 32'(key_code), 32'd8);
    checkOutput("t2_held", 32'(key_held), 32'd1);
    checkOutput("t2_latency_in_window", 32'(n >= 48 && n <= 67), 32'd1);
    repeat (160 - n) step();
    checkOutput("t2_hold_held", 32'(key_held), 32'd1);
    checkOutput("t2_hold_code", 32'(key_code), 32'd8);
    checkOutput("t2_no_repeat", 32'(valid_cnt - v0), 32'd1);
    applyStimulus(20'd0);
    waitStrobe(100, n, seen);
    checkOutput("t2_rel_seen", 32'(seen), 32'd1);
    checkOutput("t2_rel_strobe", 32'(key_release), 32'd1);
    checkOutput("t2_rel_valid", 32'(key_valid), 32'd0);
    checkOutput("t2_rel_code", 32'(key_code), 32'd0);
    checkOutput("t2_rel_held", 32'(key_held), 32'd0);
    step();
    checkOutput("t2_rel_count", 32'(release_cnt - r0), 32'd1);

    // 3: bounce on col3,row4; no two-frame-plus run is long enough to accept
    repeat (64) step();
    alignFrame("t3_align");
    v0 = valid_cnt;
    r0 = release_cnt;
    step();
    step();
    for (int i = 0; i < 20; i++) begin
      applyStimulus((i % 2 == 0) ? (20'd1 << 19) : 20'd0);
      repeat (10) step();
    end
    applyStimulus(20'd0);
    repeat (100) step();
    checkOutput("t3_valid_cnt", 32'(valid_cnt - v0), 32'd0);
    checkOutput("t3_release_cnt", 32'(release_cnt - r0), 32'd0);
    checkOutput("t3_code", 32'(key_code), 32'd0);

    // 4: held code 8, then direct switch to col0,row0 (code 1)
    applyStimulus(20'd1 << 7);
    waitStrobe(100, n, seen);
    checkOutput("t4_first_valid", 32'(key_valid), 32'd1);
    checkOutput("t4_first_code", 32'(key_code), 32'd8);
    repeat (32) step();
    alignFrame("t4_align");
    applyStimulus(20'd1);
    waitStrobe(100, n, seen);
    checkOutput("t4_seen", 32'(seen), 32'd1);
    checkOutput("t4_valid", 32'(key_valid), 32'd1);
    checkOutput("t4_release", 32'(key_release), 32'd1);
    checkOutput("t4_code", 32'(key_code), 32'd1);
    checkOutput("t4_held", 32'(key_held), 32'd1);
    applyStimulus(20'd0);
    waitStrobe(100, n, seen);
    checkOutput("t4_rel_strobe", 32'(key_release), 32'd1);
    checkOutput("t4_rel_code", 32'(key_code), 32'd0);

    // 5: two keys col0,row1 and col2,row1 together
    repeat (64) step();
    v0 = valid_cnt;
    applyStimulus((20'd1 << 1) | (20'd1 << 11));
    repeat (160) step();
    checkOutput("t5_valid_cnt", 32'(valid_cnt - v0), 32'd0);
    checkOutput("t5_code", 32'(key_code), 32'd0);
    checkOutput("t5_held", 32'(key_held), 32'd0);
    applyStimulus(20'd0);
    repeat (64) step();

    // 6: reset while code 20 is held, key stays down
    applyStimulus(20'd1 << 19);
    waitStrobe(100, n, seen);
    checkOutput("t6_first_valid", 32'(key_valid), 32'd1);
    checkOutput("t6_first_code", 32'(key_code), 32'd20);
    repeat (5) step();
    r0 = release_cnt;
    rst = 1'b1;
    step();
    rst = 1'b0;
    checkOutput("t6_rst_key_out", 32'(key_out), 32'd1);
    checkOutput("t6_rst_code", 32'(key_code), 32'd0);
    checkOutput("t6_rst_valid", 32'(key_valid), 32'd0);
    checkOutput("t6_rst_release", 32'(key_release), 32'd0);
    checkOutput("t6_rst_held", 32'(key_held), 32'd0);
    waitStrobe(100, n, seen);
    checkOutput("t6_seen", 32'(seen), 32'd1);
    checkOutput("t6_valid", 32'(key_valid), 32'd1);
    checkOutput("t6_release", 32'(key_release), 32'd0);
    checkOutput("t6_code", 32'(key_code), 32'd20);
    checkOutput("t6_latency_in_window", 32'(n >= 48 && n <= 67), 32'd1);
    checkOutput("t6_no_release", 32'(release_cnt - r0), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/key_scan_debounce.md
Name: key_scan_debounce

Overview:
- Matrix keypad front-end for the timer.
- Drives a one-hot 4-column scan and reads 5 row-sense lines, giving 20 keys.
- Synchronises and debounces the raw matrix, then delivers one clean key code with press and release strobes to the timer_top control FSM.
- Sits directly between the physical keypad pins and the timer setting/start logic.

Parameters:
- SCAN_DIV, 1000: clock cycles each column is driven. Minimum 4. At the 10 MHz board clock this is 100 us per column.
- DEBOUNCE_FRAMES, 50: consecutive identical full-scan frames required to accept a new key state. Minimum 2.

Ports:
- i_clk  input  1  system clock
- i_rst  input  1  synchronous reset, active-high
- i_key_in  input  5  row sense from keypad, active-high, asynchronous to i_clk
- o_key_out  output  4  column drive, one-hot, active-high
- o_key_code  output  5  debounced key code: 0 = no key, 1..20 = key
- o_key_valid  output  1  one-cycle strobe: new key accepted (o_key_code valid in the same cycle)
- o_key_release  output  1  one-cycle strobe: accepted key released
- o_key_held  output  1  level, high while o_key_code != 0

Behaviour:
- Reset: i_rst is sampled on the rising edge of i_clk. On the next edge:
  - o_key_out = 4'b0001; o_key_code = 0; o_key_valid = o_key_release = o_key_held = 0.
  - Column counter, divider, frame accumulator, candidate, stable counter and synchroniser flops are all cleared.
  - Reset mid-scan or mid-debounce discards all partial state; no strobe is emitted.
- Synchroniser: i_key_in passes through a 2-flop synchroniser before any use.
- Scan:
  - A divider counts 0..SCAN_DIV-1; the column index increments when the divider wraps.
  - Column order is 0,1,2,3,0…; o_key_out = 1 << col.
  - Synchronised rows are sampled only on divider value SCAN_DIV-1. This leaves ≥2 cycles of settling plus synchroniser delay.
- Frame decode: over columns 0..3 the block records every asserted (col,row).
  - Exactly one hit: frame result = col*5 + row + 1, giving a range of 1..20.
  - Zero hits: frame result = 0.
  - Two or more hits (ghost or multi-press): frame result = 0.
  - The frame completes on the sample of column 3; the accumulator is then cleared for the next frame.
- Debounce, evaluated once per completed frame:
  - If frame result == candidate: stable counter increments, saturating at DEBOUNCE_FRAMES-1.
  - Else: candidate = frame result and stable counter = 0.
  - When the counter reaches DEBOUNCE_FRAMES-1 and candidate != o_key_code, the state is accepted on that cycle, as follows.
- Acceptance:
  - 0 → K: o_key_code = K, o_key_valid = 1 for one cycle, o_key_held = 1.
  - K → 0: o_key_code = 0, o_key_release = 1 for one cycle, o_key_held = 0.
  - K1 → K2 (direct change, both nonzero): o_key_code = K2, and o_key_release and o_key_valid are both pulsed in the same cycle.
- Holding a key emits no further strobes: there is no auto-repeat.
- Latency: from i_key_in stable to strobe is at least DEBOUNCE_FRAMES frames and at most DEBOUNCE_FRAMES+1 frames, plus 3 cycles. One frame = 4*SCAN_DIV cycles.
- Width rules:
  - Divider width = clog2(SCAN_DIV).
  - Stable counter width = clog2(DEBOUNCE_FRAMES).
  - The code arithmetic fits in 5 bits; no overflow is possible.

Test Plan:
All scenarios use SCAN_DIV=4 and DEBOUNCE_FRAMES=3, giving a frame of 16 cycles.
1. Reset released, no keys, run 200 cycles. Required:
   - o_key_out cycles 0001→0010→0100→1000, changing every 4 cycles.
   - o_key_code = 0 and no strobes throughout.
2. Key at col1,row2 (row 2 asserted only while o_key_out[1]=1), held for 10 frames. Required:
   - A single o_key_valid with o_key_code = 8, occurring 48–67 cycles after press.
   - o_key_held = 1 until release.
   - After release, one o_key_release, and o_key_code = 0.
3. Bounce: key col3,row4 toggled every 10 cycles for 200 cycles, then released. Required: no strobes, o_key_code stays 0.
4. Held key code 8, then switched directly to col0,row0. Required: after debounce, o_key_valid and o_key_release are both high in the same cycle, and o_key_code = 1.
5. Two keys, col0,row1 and col2,row1, pressed together for 10 frames. Required: no o_key_valid, o_key_code = 0.
6. i_rst asserted for 1 cycle while code 20 (col3,row4) is held. Required:
   - Next edge: all outputs at reset values and o_key_out = 0001.
   - With the key still held, a fresh o_key_valid with code 20 follows 48–67 cycles later.
